sync_fifo_prog: RTL

//  Single-clock FIFO with programmable almost-full/almost-empty flags, fill-level output,

---
 rtl/sync_fifo_prog_pkg.sv | 31 +++
 rtl/sync_fifo_prog_ram.sv | 52 +++++
 rtl/sync_fifo_prog.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_prog_pkg.sv
// sync_fifo_prog_pkg
//   Shared helpers for the single-clock FIFO family: width calculations for
//   read/write pointers and the fill-level counter. Imported by every FIFO
//   variant so that all of them size their counters the same way.
//   No ports (package).
package sync_fifo_prog_pkg;

    // Ceiling log2. clog2(1) = 0, clog2(5) = 3, clog2(8) = 3.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Pointer width. It is never narrower than one bit.
    function automatic int ptrWidth(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // The fill level has to represent 0..depth inclusive.
    function automatic int countWidth(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_ram.sv
// sync_fifo_prog_ram
//   Simple dual-port RAM used as FIFO storage. It has one write port and one
//   read port, and the read port is registered.
//   A write and a read to the same address in the same cycle returns the old
//   word (read-before-write).
//   The storage array is not reset. Only the read-data register is cleared,
//   so that the FIFO output reads as zero after reset.
// Ports
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (read register only)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable (loads rdata_o on the next edge)
//   raddr_i  : read address
//   rdata_o  : registered read data
module sync_fifo_prog_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking update gives read-before-write on an address collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
//   Single-clock FIFO with the following features:
//     - programmable almost-full and almost-empty thresholds
//     - fill-level output
//     - sticky overflow and underflow error flags
//   Depth need not be a power of two; the pointers wrap explicitly.
//   Build option: define SYNC_FIFO_PROG_FWFT_EN for first-word-fall-through.
//   In that mode the head word is always presented on o_rdata while o_rvalid=1,
//   and i_rden pops it. Otherwise o_rdata is registered with one cycle of
//   latency after an accepted read.
// Ports
//   i_sys_clk   : clock, rising edge
//   i_sys_rst_n : asynchronous active-low reset
//   i_wren      : write request
//   i_wdata     : write data
//   i_rden      : read request (pop in FWFT mode)
//   i_clr_err   : clears o_overflow / o_underflow
//   o_rdata     : read data
//   o_rvalid    : o_rdata valid
//   o_full      : count == DATA_DEPTH
//   o_empty     : count == 0
//   o_afull     : count >= AFULL_THRESH
//   o_aempty    : count <= AEMPTY_THRESH
//   o_count     : fill level
//   o_overflow  : sticky, a write was refused
//   o_underflow : sticky, a read was attempted while empty
module sync_fifo_prog
    import sync_fifo_prog_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_DEPTH    = 128,
    parameter int AFULL_THRESH  = 112,
    parameter int AEMPTY_THRESH = 16
) (
    input  logic                          i_sys_clk,
    input  logic                          i_sys_rst_n,
    input  logic                          i_wren,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    input  logic                          i_rden,
    input  logic                          i_clr_err,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_rvalid,
    output logic                          o_full,
    output logic                          o_empty,
    output logic                          o_afull,
    output logic                          o_aempty,
    output logic [clog2(DATA_DEPTH):0]    o_count,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int PW = ptrWidth(DATA_DEPTH);
    localparam int CW = countWidth(DATA_DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rd_acc, wr_acc;
    logic                  ram_re;
    logic [PW-1:0]         ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // A write on a full FIFO is accepted only when a read frees a slot in the
    // same cycle. A read on an empty FIFO is never bypassed from the write.
    always_comb begin
        rd_acc   = i_rden & (count_q != '0);
        wr_acc   = i_wren & ((count_q != CW'(DATA_DEPTH)) | rd_acc);

        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(DATA_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PW'(DATA_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A set event overrides a clear in the same cycle.
        ovf_d = i_clr_err ? 1'b0 : ovf_q;
        unf_d = i_clr_err ? 1'b0 : unf_q;
        if (i_wren & ~wr_acc) begin
            ovf_d = 1'b1;
        end
        if (i_rden & (count_q == '0)) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef SYNC_FIFO_PROG_FWFT_EN
    // The RAM reads the next head address every cycle, so its register always
    // holds mem[rd_ptr_q].
    // A write landing on that same address this cycle would be missed by the
    // read-before-write RAM. Such a write is captured here and presented
    // instead of the RAM output.
    logic                  bypass_q, bypass_d;
    logic [DATA_WIDTH-1:0] byp_data_q;

    assign ram_re    = 1'b1;
    assign ram_raddr = rd_ptr_d;
    assign bypass_d  = wr_acc & (wr_ptr_q == rd_ptr_d);

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            bypass_q   <= 1'b0;
            byp_data_q <= '0;
        end else begin
            bypass_q   <= bypass_d;
            byp_data_q <= i_wdata;
        end
    end

    assign o_rdata  = bypass_q ? byp_data_q : ram_rdata;
    assign o_rvalid = (count_q != '0);
`else
    logic rvalid_q;

    assign ram_re    = rd_acc;
    assign ram_raddr = rd_ptr_q;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
        end
    end

    assign o_rdata  = ram_rdata;
    assign o_rvalid = rvalid_q;
`endif

    sync_fifo_prog_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_WIDTH (PW)
    ) u_ram (
        .clk_i   (i_sys_clk),
        .rst_ni  (i_sys_rst_n),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign o_count     = count_q;
    assign o_empty     = (count_q == '0);
    assign o_full      = (count_q == CW'(DATA_DEPTH));
    assign o_afull     = (count_q >= CW'(AFULL_THRESH));
    assign o_aempty    = (count_q <= CW'(AEMPTY_THRESH));
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule
